writeback: RTL and testbench
============================

Name: writeback

Overview:
- Y86-64 pipeline write-back stage and owner of the 16-entry register file.
- Latches the W pipeline register from memory-stage outputs and commits dstE/dstM results to the register file.
- Exposes two combinational read ports plus W_* forwarding values to the decode stage.
- Tracks processor status with a sticky run/stop state machine and counts retired instructions.

Parameters:
- RSP_INIT, 154, reset value of register 4 (%rsp)
- RNONE, 15, register ID meaning "no register"; never written, reads return 0

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- W_stall  input  1  hold W register contents
- W_bubble  input  1  load bubble into W register
- m_stat  input  3  status from memory stage
- M_icode  input  4  icode in M register
- M_dstE  input  4  E destination in M register
- M_dstM  input  4  M destination in M register
- M_valE  input  64  ALU result in M register
- m_valM  input  64  memory read data
- srcA  input  4  read port A address, from decode
- srcB  input  4  read port B address, from decode
- rvalA  output  64  register-file read data A
- rvalB  output  64  register-file read data B
- W_stat  output  3  W register status
- W_icode  output  4  W register icode
- W_dstE  output  4  W register E destination, for forwarding
- W_dstM  output  4  W register M destination, for forwarding
- W_valE  output  64  W register valE, for forwarding
- W_valM  output  64  W register valM, for forwarding
- stat  output  3  processor status
- halted  output  1  high once the STOP state is entered
- instr_count  output  64  retired-instruction counter

Behaviour:
- Status codes: SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4. Bubble W contents: stat=SBUB, icode=NOP (1), dstE=dstM=RNONE, valE=valM=0.
- W register update, priority order, each rising edge:
  - rst: load bubble.
  - W_bubble: load bubble (W_bubble wins over W_stall).
  - W_stall: hold.
  - otherwise: load m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM.
  - W_* outputs are the registered values directly.
- Register file reset: all entries 0, entry 4 = RSP_INIT.
- Commit, combinational on W register contents; the write takes effect at the next rising edge:
  - Enabled only when state is RUN and W_stat is SAOK.
  - W_dstE != RNONE: reg[W_dstE] <= W_valE.
  - W_dstM != RNONE: reg[W_dstM] <= W_valM.
  - W_dstE == W_dstM (e.g. popq %rsp): valM wins.
  - Non-SAOK and bubble entries never write.
- Read ports:
  - Combinational: rvalX = reg[srcX]; srcX == RNONE returns 0.
  - No internal write-to-read bypass. A value being committed this cycle appears on reads only after the edge; decode covers the gap by forwarding from W_*.
- State machine, states RUN and STOP:
  - Reset enters RUN.
  - RUN -> STOP at the edge where W_stat is SHLT, SADR or SINS. That instruction does not commit.
  - STOP is sticky until rst.
  - In STOP, all register writes are suppressed and the W register keeps updating normally.
- stat output:
  - RUN with W_stat == SBUB: SAOK.
  - RUN otherwise: W_stat.
  - STOP: the status latched on entry, held constant.
- halted: 1 in STOP, 0 in RUN.
- instr_count:
  - Reset 0.
  - Increments by 1 on each edge where state is RUN and W_stat is SAOK.
  - Also increments when the SAOK entry has dstE = dstM = RNONE (e.g. nop, jXX).
  - Wraps modulo 2^64.
- Reset mid-operation: all state reinitialised in the same edge; any pending commit is discarded.
- Latency: an M-stage result is in W one cycle later and visible on read ports one further cycle later.

Decomposition:
- Shared package y86_pkg holds:
  - status codes SBUB/SAOK/SHLT/SADR/SINS
  - icode constants (NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ)
  - RNONE and RRSP (4)
  - a W-register bundle type
- One sub-module, regfile16x64:
  - two combinational read ports and two write ports with port-M priority
  - synchronous reset with RSP_INIT
  - instantiated once here

Test Plan:
- Reset then idle bubbles -> reg4=154, all other regs read 0, stat=SAOK, halted=0, instr_count=0.
- Feed irmovq: M_dstE=2, M_valE=0x55, stat SAOK -> W_valE=0x55 after 1 edge, rvalA(srcA=2)=0x55 after 2 edges, instr_count=1.
- Feed popq %rsp: dstE=4, valE=0x100, dstM=4, valM=0x77 -> reg4=0x77.
- Assert W_stall for 3 cycles after loading an entry -> W_* held, entry commits and is counted once per edge (3 increments); then W_bubble -> W_stat=0, no writes.
- Feed SADR entry with dstE=3, then an SAOK entry with dstE=5 -> reg3 and reg5 unchanged, stat=3, halted=1 and stays 1; rst -> RUN, regs reinitialised.
- Assert rst on the same edge as a pending commit to reg 6 -> reg6=0 after the edge.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes, register IDs and the W pipeline register bundle.
package y86_pkg;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'ha;
    localparam logic [3:0] POPQ   = 4'hb;

    localparam logic [3:0] RRSP  = 4'd4;
    localparam logic [3:0] RNONE = 4'd15;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_m;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{stat: SBUB, icode: NOP, dst_e: RNONE, dst_m: RNONE,
                                    val_e: 64'd0, val_m: 64'd0};

endpackage

// File: rtl/regfile16x64.sv
// regfile16x64: 16x64 register file, two combinational read ports, two write ports with port M winning.
module regfile16x64 #(
    parameter logic [63:0] RSP_INIT = 64'd154
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m
);
    import y86_pkg::*;

    logic [63:0] regs_q [16];
    logic [63:0] regs_d [16];

    always_comb begin
        regs_d = regs_q;
        if (we_e && dst_e != RNONE) regs_d[dst_e] = val_e;
        if (we_m && dst_m != RNONE) regs_d[dst_m] = val_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'd0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rval_a = (src_a == RNONE) ? 64'd0 : regs_q[src_a];
    assign rval_b = (src_b == RNONE) ? 64'd0 : regs_q[src_b];

endmodule

// File: rtl/writeback.sv
// writeback: Y86-64 write-back stage owning the register file, with sticky RUN/STOP status and retire counter.
module writeback #(
    parameter logic [63:0] RSP_INIT = 64'd154
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [2:0]  m_stat,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] rvalA,
    output logic [63:0] rvalB,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [63:0] instr_count
);
    import y86_pkg::*;

    typedef enum logic {RUN, STOP} state_t;

    state_t      state_q, state_d;
    w_reg_t      w_q, w_d, w_in;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] count_q, count_d;
    logic        commit;

    assign w_in = '{stat: m_stat, icode: M_icode, dst_e: M_dstE, dst_m: M_dstM,
                    val_e: M_valE, val_m: m_valM};

    always_comb begin
        w_d     = W_bubble ? W_BUBBLE : W_stall ? w_q : w_in;
        commit  = state_q == RUN && w_q.stat == SAOK;
        state_d = (state_q == RUN && w_q.stat inside {SHLT, SADR, SINS}) ? STOP : state_q;
        // while running this tracks W_stat, so it already holds the faulting code on entry to STOP
        stat_d  = state_q == RUN ? w_q.stat : stat_q;
        count_d = count_q + {63'd0, commit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= W_BUBBLE;
            state_q <= RUN;
            stat_q  <= SAOK;
            count_q <= 64'd0;
        end else begin
            w_q     <= w_d;
            state_q <= state_d;
            stat_q  <= stat_d;
            count_q <= count_d;
        end
    end

    regfile16x64 #(.RSP_INIT(RSP_INIT)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .src_a (srcA),
        .src_b (srcB),
        .rval_a(rvalA),
        .rval_b(rvalB),
        .we_e  (commit),
        .dst_e (w_q.dst_e),
        .val_e (w_q.val_e),
        .we_m  (commit),
        .dst_m (w_q.dst_m),
        .val_m (w_q.val_m)
    );

    assign W_stat      = w_q.stat;
    assign W_icode     = w_q.icode;
    assign W_dstE      = w_q.dst_e;
    assign W_dstM      = w_q.dst_m;
    assign W_valE      = w_q.val_e;
    assign W_valM      = w_q.val_m;
    assign stat        = state_q == STOP ? stat_q : w_q.stat == SBUB ? SAOK : w_q.stat;
    assign halted      = state_q == STOP;
    assign instr_count = count_q;

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: scoreboard bench for the write-back stage, register file and status FSM.
module tb_writeback;
    import y86_pkg::*;

    logic        clk = 0;
    logic        rst = 1;
    logic        W_stall = 0;
    logic        W_bubble = 0;
    logic [2:0]  m_stat = SBUB;
    logic [3:0]  M_icode = NOP;
    logic [3:0]  M_dstE = RNONE;
    logic [3:0]  M_dstM = RNONE;
    logic [63:0] M_valE = 0;
    logic [63:0] m_valM = 0;
    logic [3:0]  srcA = 0;
    logic [3:0]  srcB = 0;
    logic [63:0] rvalA, rvalB, W_valE, W_valM, instr_count;
    logic [2:0]  W_stat, stat;
    logic [3:0]  W_icode, W_dstE, W_dstM;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;
    w_reg_t sb[$];
    w_reg_t last_w = W_BUBBLE;
    w_reg_t idle;

    writeback dut (
        .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_valE(M_valE), .m_valM(m_valM), .srcA(srcA), .srcB(srcB),
        .rvalA(rvalA), .rvalB(rvalB), .W_stat(W_stat), .W_icode(W_icode),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .stat(stat), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic w_reg_t mk(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] de,
                                  input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
        w_reg_t e;
        e.stat = s; e.icode = ic; e.dst_e = de; e.dst_m = dm; e.val_e = ve; e.val_m = vm;
        return e;
    endfunction

    task automatic cycle(input w_reg_t e);
        w_reg_t x;
        m_stat = e.stat; M_icode = e.icode; M_dstE = e.dst_e; M_dstM = e.dst_m;
        M_valE = e.val_e; m_valM = e.val_m;
        sb.push_back((rst || W_bubble) ? W_BUBBLE : W_stall ? last_w : e);
        @(posedge clk); #1;
        x = sb.pop_front();
        last_w = x;
        check("W_stat", W_stat, x.stat);
        check("W_icode", W_icode, x.icode);
        check("W_dstE", W_dstE, x.dst_e);
        check("W_dstM", W_dstM, x.dst_m);
        check("W_valE", W_valE, x.val_e);
        check("W_valM", W_valM, x.val_m);
    endtask

    task automatic rd(input logic [3:0] r, input logic [63:0] exp);
        srcA = r; srcB = r; #1;
        check($sformatf("rvalA[%0d]", r), rvalA, exp);
        check($sformatf("rvalB[%0d]", r), rvalB, exp);
    endtask

    task automatic status(input logic [2:0] s, input logic h, input logic [63:0] cnt);
        check("stat", stat, s);
        check("halted", halted, h);
        check("instr_count", instr_count, cnt);
    endtask

    initial begin
        idle = W_BUBBLE;
        cycle(idle);
        cycle(idle);
        rst = 0;
        cycle(idle);
        for (int r = 0; r < 16; r++) rd(r[3:0], r == 4 ? 64'd154 : 64'd0);
        status(SAOK, 0, 0);

        // irmovq: in W after 1 edge, readable after 2
        cycle(mk(SAOK, IRMOVQ, 4'd2, RNONE, 64'h55, 0));
        rd(2, 0);
        cycle(idle);
        rd(2, 64'h55);
        status(SAOK, 0, 1);

        // popq %rsp: valM wins over valE
        cycle(mk(SAOK, POPQ, RRSP, RRSP, 64'h100, 64'h77));
        cycle(idle);
        rd(4, 64'h77);
        status(SAOK, 0, 2);

        // stall holds W and counts once per edge, bubble then clears
        cycle(mk(SAOK, OPQ, 4'd7, RNONE, 64'h33, 0));
        W_stall = 1;
        for (int i = 0; i < 3; i++) cycle(mk(SAOK, IRMOVQ, 4'd8, RNONE, 64'h99, 0));
        rd(7, 64'h33);
        status(SAOK, 0, 5);
        W_stall = 0; W_bubble = 1;
        cycle(mk(SAOK, IRMOVQ, 4'd8, RNONE, 64'h99, 0));
        W_bubble = 0;
        cycle(idle);
        rd(8, 0);
        status(SAOK, 0, 6);

        // nop with no destinations still retires
        cycle(mk(SAOK, NOP, RNONE, RNONE, 0, 0));
        cycle(idle);
        status(SAOK, 0, 7);

        // address fault stops the machine; later entries never commit
        cycle(mk(SADR, RMMOVQ, 4'd3, RNONE, 64'haa, 0));
        check("stat_pre_stop", stat, SADR);
        cycle(mk(SAOK, IRMOVQ, 4'd5, RNONE, 64'hbb, 0));
        status(SADR, 1, 7);
        cycle(idle);
        cycle(idle);
        rd(3, 0);
        rd(5, 0);
        status(SADR, 1, 7);

        rst = 1;
        cycle(idle);
        rst = 0;
        status(SAOK, 0, 0);
        rd(4, 64'd154);
        rd(7, 0);

        // reset on the same edge as a pending commit discards it
        cycle(mk(SAOK, IRMOVQ, 4'd6, RNONE, 64'h66, 0));
        rst = 1;
        cycle(idle);
        rst = 0;
        cycle(idle);
        rd(6, 0);
        status(SAOK, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
